// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Purpose  : Shared types and constants for the LDM/STM block-transfer
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package arm_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    // Register index of the program counter
    localparam logic [3:0]  REG_PC     = 4'hF;

    // Bytes per memory word transfer
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Byte span of n word transfers
    function automatic logic [31:0] words_to_bytes(input logic [4:0] n);
        return {25'd0, n, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/reglist_scan.sv
`default_nettype none
// ============================================================================
// Module   : reglist_scan
// Purpose  : Combinational scan of a 16-bit register mask: lowest set index,
//            empty flag and population count.
// Revision : 1.0 - initial release
// ============================================================================
module reglist_scan (
    input  logic [15:0] mask,
    output logic [3:0]  lowest,
    output logic        empty,
    output logic [4:0]  count
);

    // Priority scan from the top so the lowest set bit is the last one written
    always_comb begin
        lowest = 4'd0;
        count  = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = 4'(i);
            end
            count = count + {4'd0, mask[i]};
        end
        empty = (mask == 16'd0);
    end

endmodule
`default_nettype wire

// File: rtl/ldm_stm_seq.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_seq
// Purpose  : LDM/STM block-transfer sequencer. Walks the register list in
//            ascending order, issues one word transfer per listed register,
//            then optionally writes the updated base back to Rn.
// Revision : 1.0 - initial release
// ============================================================================
module ldm_stm_seq
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        pre,
    input  logic        up,
    input  logic        wback,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    input  logic [15:0] reglist,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic [31:0] rf_rd,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  rf_ra,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        pc_we,
    output logic [31:0] pc_wd
);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic        r_busy;
    logic        r_is_load;
    logic        r_wb_en;
    logic [3:0]  r_rn;
    logic [15:0] r_mask;
    logic [31:0] r_addr;
    logic [31:0] r_final;

    logic [15:0] w_scan_in;
    logic [3:0]  w_cur;
    logic        w_empty;
    logic [4:0]  w_count;
    logic [31:0] w_span;
    logic [31:0] w_start_addr;
    logic [31:0] w_final;
    logic        w_last;

    // In IDLE the scanner sizes the incoming list; otherwise it walks the
    // remaining mask, so one scanner serves both purposes.
    assign w_scan_in = (r_state == S_IDLE) ? reglist : r_mask;

    reglist_scan u_scan (
        .mask   (w_scan_in),
        .lowest (w_cur),
        .empty  (w_empty),
        .count  (w_count)
    );

    assign w_span  = words_to_bytes(w_count);
    assign w_final = up ? (base + w_span) : (base - w_span);
    assign w_last  = (w_count == 5'd1);
    assign busy    = r_busy;

    // Lowest transfer address for each P/U addressing mode
    always_comb begin
        w_start_addr = base;
        case ({pre, up})
            2'b01:   w_start_addr = base;
            2'b11:   w_start_addr = base + WORD_BYTES;
            2'b00:   w_start_addr = base - w_span + WORD_BYTES;
            2'b10:   w_start_addr = base - w_span;
            default: w_start_addr = base;
        endcase
    end

    // State register; busy is registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    // Latch the request at start; step mask and address on each completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_load <= 1'b0;
            r_wb_en   <= 1'b0;
            r_rn      <= 4'd0;
            r_mask    <= 16'd0;
            r_addr    <= 32'd0;
            r_final   <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (start && !w_empty) begin
                r_is_load <= is_load;
                // A loaded Rn takes priority over the written-back base
                r_wb_en   <= wback && !(is_load && reglist[rn]);
                r_rn      <= rn;
                r_mask    <= reglist;
                r_addr    <= w_start_addr;
                r_final   <= w_final;
            end
        end else if (r_state == S_XFER && mem_ready) begin
            r_mask <= r_mask & ~(16'd1 << w_cur);
            r_addr <= r_addr + WORD_BYTES;
        end
    end

    // Next-state and output decode; every output is zero outside its state
    always_comb begin
        w_next    = r_state;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        rf_ra     = 4'd0;
        rf_we     = 1'b0;
        rf_wa     = 4'd0;
        rf_wd     = 32'd0;
        pc_we     = 1'b0;
        pc_wd     = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_empty ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                mem_req   = 1'b1;
                mem_addr  = r_addr;
                mem_we    = !r_is_load;
                mem_wdata = rf_rd;
                rf_ra     = w_cur;
                if (mem_ready) begin
                    if (r_is_load) begin
                        if (w_cur == REG_PC) begin
                            pc_we = 1'b1;
                            pc_wd = mem_rdata;
                        end else begin
                            rf_we = 1'b1;
                            rf_wa = w_cur;
                            rf_wd = mem_rdata;
                        end
                    end
                    if (w_last) begin
                        w_next = r_wb_en ? S_WB : S_DONE;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                rf_wa  = r_rn;
                rf_wd  = r_final;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldm_stm_seq
// Purpose  : Self-checking bench for ldm_stm_seq: directed vector table,
//            hand-written reset sequence and randomized sequences checked
//            cycle by cycle against a transfer-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        pre = 1'b0;
    logic        up = 1'b0;
    logic        wback = 1'b0;
    logic [3:0]  rn = 4'd0;
    logic [31:0] base = 32'd0;
    logic [15:0] reglist = 16'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] rf_rd = 32'd0;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  rf_ra;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_we;
    logic [31:0] pc_wd;

    int total = 0;
    int bad   = 0;

    ldm_stm_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_load   (is_load),
        .pre       (pre),
        .up        (up),
        .wback     (wback),
        .rn        (rn),
        .base      (base),
        .reglist   (reglist),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .rf_rd     (rf_rd),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rf_ra     (rf_ra),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pc_we     (pc_we),
        .pc_wd     (pc_wd)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        bit          ld;
        bit          p;
        bit          u;
        bit          w;
        logic [3:0]  rn;
        logic [31:0] base;
        logic [15:0] rl;
        int          mode;
        logic [31:0] e_first;
        bit          e_wb;
        logic [31:0] e_wbd;
        int          e_lat;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_req"},   32'(mem_req), 0);
        chk({tag, "_we"},    32'(mem_we), 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_ra"},    32'(rf_ra), 0);
        chk({tag, "_rfwe"},  32'(rf_we), 0);
        chk({tag, "_rfwa"},  32'(rf_wa), 0);
        chk({tag, "_rfwd"},  rf_wd, 0);
        chk({tag, "_pcwe"},  32'(pc_we), 0);
        chk({tag, "_pcwd"},  pc_wd, 0);
    endtask

    // Run one LDM/STM sequence from IDLE (entered at posedge+1) and check
    // every cycle against the expected transfer list. mode: 0 ready always
    // high, 1 random stalls, 2 three stall cycles before the second transfer.
    task automatic run_case(input bit ld, input bit p, input bit u, input bit w,
                            input logic [3:0] r, input logic [31:0] b,
                            input logic [15:0] rl, input int mode, input bit dup,
                            output logic [31:0] o_first, output bit o_wb,
                            output logic [31:0] o_wbd, output int o_lat);
        int          regs[$];
        int          n;
        int          stalls;
        int          cyc;
        logic [31:0] lo;
        logic [31:0] fin;
        logic [31:0] a;
        bit          exp_wb;

        regs = {};
        for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(i);
        n      = regs.size();
        lo     = u ? (b + (p ? 32'd4 : 32'd0)) : (b - 32'(4 * n) + (p ? 32'd0 : 32'd4));
        fin    = u ? (b + 32'(4 * n)) : (b - 32'(4 * n));
        exp_wb = (n != 0) && w && !(ld && rl[r]);
        o_first = 32'd0;
        o_wb    = 1'b0;
        o_wbd   = 32'd0;
        o_lat   = -1;

        start = 1'b1; is_load = ld; pre = p; up = u; wback = w;
        rn = r; base = b; reglist = rl; mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_req", 32'(mem_req), 0);
        @(posedge clk); #1;
        start = dup;
        cyc = 1;
        for (int k = 0; k < n; k++) begin
            if (mode == 0)      stalls = 0;
            else if (mode == 2) stalls = (k == 1) ? 3 : 0;
            else                stalls = $urandom_range(0, 2);
            a = lo + 32'(4 * k);
            for (int s = 0; s <= stalls; s++) begin
                mem_ready = (s == stalls);
                mem_rdata = $urandom;
                rf_rd     = $urandom;
                @(negedge clk);
                if (k == 0 && s == 0) o_first = mem_addr;
                chk("x_busy", 32'(busy), 1);
                chk("x_done", 32'(done), 0);
                chk("x_req", 32'(mem_req), 1);
                chk("x_addr", mem_addr, a);
                chk("x_we", 32'(mem_we), 32'(!ld));
                chk("x_ra", 32'(rf_ra), 32'(regs[k]));
                if (!ld) chk("x_wdata", mem_wdata, rf_rd);
                if (mem_ready && ld && regs[k] == 15) begin
                    chk("x_pcwe", 32'(pc_we), 1);
                    chk("x_pcwd", pc_wd, mem_rdata);
                    chk("x_rfwe_pc", 32'(rf_we), 0);
                end else if (mem_ready && ld) begin
                    chk("x_rfwe", 32'(rf_we), 1);
                    chk("x_rfwa", 32'(rf_wa), 32'(regs[k]));
                    chk("x_rfwd", rf_wd, mem_rdata);
                    chk("x_pcwe_rf", 32'(pc_we), 0);
                end else begin
                    chk("x_nowr_rf", 32'(rf_we), 0);
                    chk("x_nowr_pc", 32'(pc_we), 0);
                end
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
            end
        end
        mem_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        o_wb  = rf_we;
        o_wbd = rf_wd;
        if (exp_wb) begin
            chk("wb_we", 32'(rf_we), 1);
            chk("wb_wa", 32'(rf_wa), 32'(r));
            chk("wb_wd", rf_wd, fin);
            chk("wb_pcwe", 32'(pc_we), 0);
            chk("wb_req", 32'(mem_req), 0);
            chk("wb_done", 32'(done), 0);
            @(posedge clk); #1;
            cyc++;
            @(negedge clk);
        end
        chk("dn_done", 32'(done), 1);
        chk("dn_busy", 32'(busy), 1);
        chk("dn_req", 32'(mem_req), 0);
        chk("dn_rfwe", 32'(rf_we), 0);
        if (done) o_lat = cyc;
        @(posedge clk); #1;
        @(negedge clk);
        chk("end_done", 32'(done), 0);
        chk("end_busy", 32'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] o_first;
        logic [31:0] o_wbd;
        bit          o_wb;
        int          o_lat;

        tbl[0] = '{1, 0, 1, 1, 4'd5, 32'h0000_0100, 16'h000E, 0, 32'h0000_0100, 1, 32'h0000_010C, 5};
        tbl[1] = '{0, 1, 0, 1, 4'd2, 32'h0000_0200, 16'h4010, 0, 32'h0000_01F8, 1, 32'h0000_01F8, 4};
        tbl[2] = '{1, 1, 1, 1, 4'd1, 32'h0000_0300, 16'h8003, 0, 32'h0000_0304, 0, 32'h0, 4};
        tbl[3] = '{1, 0, 1, 0, 4'd8, 32'h0000_0400, 16'h0006, 2, 32'h0000_0400, 0, 32'h0, 6};
        tbl[4] = '{0, 0, 1, 1, 4'd3, 32'h0000_0700, 16'h0000, 0, 32'h0, 0, 32'h0, 1};
        tbl[5] = '{0, 0, 0, 1, 4'd3, 32'h0000_0004, 16'h0101, 0, 32'h0, 1, 32'hFFFF_FFFC, 4};
        tbl[6] = '{0, 0, 1, 1, 4'd0, 32'hFFFF_FFF0, 16'hFFFF, 0, 32'hFFFF_FFF0, 1, 32'h0000_0030, 18};
        tbl[7] = '{1, 1, 0, 1, 4'd0, 32'h0000_1000, 16'h0001, 0, 32'h0000_0FFC, 0, 32'h0, 2};

        // Reset state with live inputs present
        rf_rd = 32'hDEAD_BEEF; mem_rdata = 32'h1234_5678; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int t = 0; t < 8; t++) begin
            run_case(tbl[t].ld, tbl[t].p, tbl[t].u, tbl[t].w, tbl[t].rn, tbl[t].base,
                     tbl[t].rl, tbl[t].mode, 1'b0, o_first, o_wb, o_wbd, o_lat);
            chk($sformatf("tbl%0d_first", t), o_first, tbl[t].e_first);
            chk($sformatf("tbl%0d_wb", t), 32'(o_wb), 32'(tbl[t].e_wb));
            chk($sformatf("tbl%0d_wbd", t), o_wbd, tbl[t].e_wbd);
            chk($sformatf("tbl%0d_lat", t), 32'(o_lat), 32'(tbl[t].e_lat));
        end

        // Reset asserted during the second of four transfers
        start = 1'b1; is_load = 1'b1; pre = 1'b0; up = 1'b1; wback = 1'b1;
        rn = 4'd1; base = 32'h0000_0500; reglist = 16'h00F0;
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_req", 32'(mem_req), 1);
        chk("mid_addr", mem_addr, 32'h0000_0504);
        reset_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("arst_hold");
        @(posedge clk); #1;
        reset_n = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        run_case(1, 0, 1, 1, 4'd5, 32'h0000_0100, 16'h000E, 0, 1'b1,
                 o_first, o_wb, o_wbd, o_lat);
        chk("post_rst_first", o_first, 32'h0000_0100);
        chk("post_rst_wbd", o_wbd, 32'h0000_010C);
        chk("post_rst_lat", 32'(o_lat), 32'd5);

        // Randomized sequences against the reference model
        for (int it = 0; it < 40; it++) begin
            logic [15:0] rl;
            rl = (($urandom % 8) == 0) ? 16'd0 : 16'($urandom);
            run_case(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     4'($urandom_range(0, 14)), $urandom & 32'hFFFF_FFFC, rl,
                     1, 1'($urandom), o_first, o_wb, o_wbd, o_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Multi-cycle block-transfer sequencer for LDM/STM in the ARM datapath. It walks a 16-bit register list in ascending order and generates one memory word transfer per listed register. For LDM it writes each loaded word into the register file write port; for STM it reads each register through the register file third read port. It then optionally writes the updated base back to Rn. It sits between the decode/control unit and the register file/data memory, and stalls the pipeline while `busy` is high.

## Interface
- No parameters; data width fixed at 32, register index at 4.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `is_load` input 1: 1 = LDM, 0 = STM.
- `pre` input 1: P bit (increment/decrement before).
- `up` input 1: U bit.
- `wback` input 1: W bit.
- `rn` input 4: base register index.
- `base` input 32: Rn value at start.
- `reglist` input 16: bit i set = transfer Ri.
- `mem_rdata` input 32: load data, valid when `mem_ready`.
- `mem_ready` input 1: memory completes current transfer at this edge.
- `rf_rd` input 32: register file read data for `rf_ra`; r15 reads as PC+8.
- `busy` output 1: sequence in progress; stall request.
- `done` output 1: one-cycle completion pulse.
- `mem_req` output 1: transfer request.
- `mem_we` output 1: store strobe, qualified by `mem_req`.
- `mem_addr` output 32: word address.
- `mem_wdata` output 32: equal to `rf_rd`.
- `rf_ra` output 4: read index for STM.
- `rf_we` output 1: register file write enable.
- `rf_wa` output 4: write index.
- `rf_wd` output 32: write data.
- `pc_we` output 1: LDM loads r15.
- `pc_wd` output 32: new PC value.

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE + `start`, list non-empty: latch inputs. Set `count` = popcount(reglist). Go to XFER.
- IDLE + `start`, empty list: go straight to DONE. No transfers, no writeback.
- Start address, computed modulo 2^32:
  - IA (P=0,U=1): base.
  - IB (P=1,U=1): base+4.
  - DA (P=0,U=0): base−4·count+4.
  - DB (P=1,U=0): base−4·count.
- Final base: U ? base+4·count : base−4·count.
- XFER: current register = lowest remaining set bit.
  - `mem_req`=1; `mem_addr` = current address.
  - `mem_we` = !is_load; `rf_ra` = current register.
- When `mem_ready`=1 at an edge: clear that bit and add 4 to the address.
- LDM, current register ≠ 15: in the ready cycle, `rf_we`=1, `rf_wa`=current register, `rf_wd`=mem_rdata. This is combinational; the register file commits on its own edge.
- LDM, current register = 15: `pc_we`=1 and `pc_wd`=mem_rdata instead of `rf_we`.
- Last transfer completes: go to WB if `wback` and not (is_load and reglist[rn]). Otherwise go to DONE.
- LDM with Rn in the list: the loaded value wins and writeback is suppressed.
- WB: one cycle with `rf_we`=1, `rf_wa`=rn, `rf_wd`=final base. Then go to DONE.
- WB with rn=15 is not supported. Decode never issues it, and the block must not drive `pc_we` in WB.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset (async assert, sync release): state IDLE; every output 0, including `mem_addr`, `rf_wd`, `pc_wd`.
- `busy` = (state ≠ IDLE), registered. It rises in the cycle after the `start` edge.
- With `mem_ready` tied high: N transfers take N XFER cycles, plus 1 WB cycle if writeback, plus 1 DONE cycle.
- `mem_ready` low: hold `mem_addr`, `mem_we` and `rf_ra` stable. Assert no writes.
- Reset mid-sequence: immediate IDLE. No further `mem_req`, `rf_we` or `pc_we`. Partial loads already committed stay committed.
- `mem_addr` wraps modulo 2^32; no alignment check, because inputs are word-aligned by construction.

## Structure
- Shared package `arm_pkg`:
  - state enum `seq_state_t`.
  - constant `REG_PC` = 4'hF.
  - constant `WORD_BYTES` = 4.
- Sub-module `reglist_scan` (combinational): inputs are the 16-bit remaining mask; outputs are the lowest set index, `empty`, and the 5-bit popcount.
- Sequencer FSM, address counter and mask register stay in the top module.

## Test plan
- LDM IA, reglist=0x000E, base=0x100, W=1, ready high → loads r1..r3 from 0x100/0x104/0x108; WB writes Rn=0x10C; `done` 5 cycles after `start`.
- STM DB, reglist=0x4010, base=0x200, W=1 → r4 stored @0x1F8, r14 @0x1FC, `mem_we`=1 on both; Rn=0x1F8.
- LDM IB with bit 15 set and Rn in list, W=1 → `pc_we` pulses with data from the highest address; no WB cycle; Rn holds the loaded value.
- `mem_ready` held low 3 cycles mid-transfer → `mem_addr` stable, no `rf_we`; sequence resumes correctly.
- Empty reglist with `start` → `done` one cycle later; no `mem_req`, no `rf_we`.
- `reset_n` asserted during the second of four transfers → all outputs 0 immediately; next `start` runs a clean sequence; second `start` while busy ignored.
